// File: rtl/de_mux1to8.sv
// Registered 1-to-8 demultiplexer: d is routed to output {a,b,c} on each clock
// edge while en is high; every other output (or all of them, with en low) loads zero.
module de_mux1to8 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7
);

  logic [2:0]         sel;
  logic [8*WIDTH-1:0] y_bus;

  assign sel = {a, b, c};

  // Each lane decodes its own select match, so only one lane can ever load d.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [WIDTH-1:0] y_next;
      logic [WIDTH-1:0] y_reg;

      always_comb begin
        y_next = '0;
        if (en && (sel == 3'(gi)))
          y_next = d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          y_reg <= '0;
        else
          y_reg <= y_next;
      end

      assign y_bus[gi*WIDTH +: WIDTH] = y_reg;
    end
  endgenerate

  assign y0 = y_bus[0*WIDTH +: WIDTH];
  assign y1 = y_bus[1*WIDTH +: WIDTH];
  assign y2 = y_bus[2*WIDTH +: WIDTH];
  assign y3 = y_bus[3*WIDTH +: WIDTH];
  assign y4 = y_bus[4*WIDTH +: WIDTH];
  assign y5 = y_bus[5*WIDTH +: WIDTH];
  assign y6 = y_bus[6*WIDTH +: WIDTH];
  assign y7 = y_bus[7*WIDTH +: WIDTH];

endmodule

// File: tb/tb_de_mux1to8.sv
// Scoreboard bench for de_mux1to8 (WIDTH=4): stimulus pushes the expected output
// set per cycle, a monitor pops and compares one edge later.
module tb_de_mux1to8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, a, b, c;
  logic [W-1:0] d;
  logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [8*W-1:0] y_all;

  int errors = 0;
  int checks = 0;
  int txn = 0;
  bit done = 1'b0;

  logic [8*W-1:0] exp_q[$];
  int             tag_q[$];

  de_mux1to8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .a(a), .b(b), .c(c),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7)
  );

  assign y_all = {y7, y6, y5, y4, y3, y2, y1, y0};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: the selected output holds d only if out of reset and enabled.
  function automatic logic [8*W-1:0] model(input bit rst_ok, input bit e,
                                           input logic [W-1:0] dv, input int s);
    logic [8*W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (rst_ok && e && i == s) r[i*W +: W] = dv;
    return r;
  endfunction

  // Drive one cycle's inputs on the falling edge and record what the next rising edge must produce.
  task automatic cycle(input bit r, input bit e, input logic [W-1:0] dv, input int s);
    logic [2:0] sv;
    @(negedge clk);
    sv = 3'(s);
    rst_n = r; en = e; d = dv;
    {a, b, c} = sv;
    exp_q.push_back(model(r, e, dv, s));
    tag_q.push_back(txn);
    txn++;
  endtask

  // Monitor: every rising edge that has an outstanding expectation is compared.
  initial begin
    logic [8*W-1:0] e;
    int t, nz;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check($sformatf("txn%0d", t), y_all, e);
        nz = 0;
        for (int i = 0; i < 8; i++) if (y_all[i*W +: W] != '0) nz++;
        checks++;
        if (nz > 1) begin
          errors++;
          $display("FAIL onehot txn%0d: %0d nonzero outputs, at most 1 allowed", t, nz);
        end
        $display("txn%0d outputs=%h expected=%h", t, y_all, e);
      end
    end
  end

  initial begin
    int wait_cnt;
    rst_n = 1'b0; en = 1'b0; d = '0; {a, b, c} = 3'b000;
    #1;
    check("reset_state", y_all, '0);
    repeat (2) @(negedge clk);

    // Walk every select with d=1
    for (int s = 0; s < 8; s++) cycle(1'b1, 1'b1, 4'h1, s);
    // Data zero gives all-zero outputs for any select
    for (int s = 0; s < 8; s++) cycle(1'b1, 1'b1, 4'h0, s);

    // Enable low clears, enable high restores
    cycle(1'b1, 1'b1, 4'h1, 5);
    cycle(1'b1, 1'b0, 4'h1, 5);
    cycle(1'b1, 1'b1, 4'h1, 5);

    // Async reset mid-cycle
    cycle(1'b1, 1'b1, 4'h1, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", y_all, '0);
    cycle(1'b0, 1'b1, 4'h1, 3);
    cycle(1'b0, 1'b1, 4'h1, 3);
    cycle(1'b1, 1'b1, 4'h1, 3);

    // Select change 010 -> 110 does not show before the edge
    cycle(1'b1, 1'b1, 4'h1, 2);
    cycle(1'b1, 1'b1, 4'h1, 6);
    #1;
    check("hold_between_edges", y_all, model(1'b1, 1'b1, 4'h1, 2));
    cycle(1'b1, 1'b1, 4'h1, 6);

    // Full-width data routing
    cycle(1'b1, 1'b1, 4'hA, 7);
    cycle(1'b1, 1'b1, 4'h5, 0);

    // Random traffic with occasional enable drops and resets
    for (int k = 0; k < 200; k++)
      cycle($urandom_range(0, 19) != 0, $urandom_range(0, 4) != 0,
            W'($urandom), int'($urandom_range(0, 7)));

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/de_mux1to8.md
DE_MUX1TO8 -- requirements
Module: de_mux1to8

Interface
REQ-001 Parameter WIDTH, default 1: bit width of data input d and of each output y0..y7.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  update enable; 1 = outputs follow decoded data on the next edge, 0 = outputs cleared on the next edge.
REQ-005 d  input  WIDTH  data to be routed.
REQ-006 a  input  1  select bit 2 (MSB).
REQ-007 b  input  1  select bit 1.
REQ-008 c  input  1  select bit 0 (LSB).
REQ-009 y0..y7  output  WIDTH each  routed data outputs; index = {a,b,c} as an unsigned 3-bit value.

Function
REQ-010 The block SHALL form sel = {a,b,c}, with a as MSB and c as LSB; e.g. a=1,b=0,c=0 selects y4.
REQ-011 On each rising clk edge with rst_n=1 and en=1, y[sel] SHALL load d and all seven other outputs SHALL load 0.
REQ-012 On each rising clk edge with rst_n=1 and en=0, all eight outputs SHALL load 0.
REQ-013 Outputs SHALL be registered: latency from d/a/b/c/en change to output change is exactly one rising clk edge; outputs SHALL NOT change combinationally between edges.
REQ-014 At most one output SHALL be nonzero at any time; with d=0 all outputs SHALL be 0 regardless of select.
REQ-015 A select change between edges SHALL move d to the new output and zero the previous output on the same edge, with no cycle where both are nonzero.
REQ-016 For WIDTH>1, all WIDTH bits of d SHALL be routed together to the selected output, with no bit reordering.
REQ-017 Unknown (X/Z) select bits are outside the defined input domain; no output behaviour is specified for them.

Reset
REQ-018 While rst_n=0, all outputs y0..y7 SHALL be 0 immediately, independent of clk.
REQ-019 Reset assertion mid-operation SHALL clear all outputs asynchronously, discarding the pending update.
REQ-020 After rst_n deasserts, the first rising clk edge SHALL apply REQ-011/REQ-012 normally.
REQ-021 If rst_n deasserts coincident with a clk edge, outputs SHALL remain 0 for that edge; updates begin on the following edge.

Verification
REQ-022 Walk all selects: rst_n=1, en=1, d=1, {a,b,c}=000..111, one per cycle -> one edge later only y0..y7 respectively =1, all others 0.
REQ-023 Data zero: d=0, en=1, any select -> all outputs 0 after the next edge.
REQ-024 Enable low: output y5=1 (d=1, sel=101) established, then en=0 -> all outputs 0 after the next edge; en=1 again -> y5=1 after the following edge.
REQ-025 Async reset: y3=1 established, rst_n driven low between edges -> all outputs 0 immediately, before any clk edge; they stay 0 until after rst_n=1 and the next edge.
REQ-026 Latency and one-hot: change select 010->110 mid-cycle with d=1 -> y2 stays 1 until the edge, then y6=1 and y2=0 on that same edge; no cycle shows two outputs nonzero.
REQ-027 WIDTH=4: d=4'hA, sel=111 -> y7=4'hA, all others 4'h0 after the next edge.
